// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic master; command to stb 1 edge, ack to rsp_valid 1 edge.
// cmd_ready only while idle; response held until rsp_ready; bus timeout returns rsp_err.
module wishbone_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_int_i,
  output logic        irq_pulse
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } req_t;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  req_t        req_q, req_d;
  rsp_t        rsp_q, rsp_d;
  logic        cyc_q, cyc_d;
  logic        rdy_q, rdy_d;
  logic        int_prev_q;
  logic        irq_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          req_d   = '{we: cmd_we, adr: cmd_addr, dat: cmd_wdata};
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack takes priority over an expiring timeout on the same edge
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          rsp_d   = '{vld: 1'b1, err: 1'b0, dat: (req_q.we ? 32'd0 : wb_dat_i)};
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d   = 1'b0;
          rsp_d   = '{vld: 1'b1, err: 1'b1, dat: 32'd0};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_d.vld = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // registered so it stays low through reset and rises on the first edge after release
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
      cyc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cyc_q   <= cyc_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      int_prev_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      int_prev_q <= wb_int_i;
      irq_q      <= wb_int_i & ~int_prev_q;
    end
  end

  assign cmd_ready = rdy_q;
  assign wb_adr_o  = req_q.adr;
  assign wb_dat_o  = req_q.dat;
  assign wb_we_o   = req_q.we;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign rsp_valid = rsp_q.vld;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.dat;
  assign irq_pulse = irq_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Randomized bench for wishbone_master: slave model, scoreboard queues and a decoupled monitor.
module tb_wishbone_master;

  localparam int T = 4;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_int_i, irq_pulse;

  wishbone_master #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_int_i(wb_int_i), .irq_pulse(irq_pulse)
  );

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // expected response data
    bit          err;
    int          len;     // expected stb-high cycles
    int          k;       // slave wait cycles before ack
    logic [31:0] sdat;    // data the slave returns
  } item_t;

  item_t slv_q[$];
  item_t bus_q[$];
  item_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int rsp_mode = 0;  // 0 random, 1 forced low, 2 forced high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: ack after k wait cycles is seen iff it lands no later than cycle T.
  function automatic item_t make_item(input bit we, input logic [7:0] a, input logic [31:0] wd,
                                      input logic [31:0] sd, input int k);
    item_t it;
    it.we = we; it.addr = a; it.wdata = wd; it.k = k; it.sdat = sd;
    it.err   = (k >= T);
    it.len   = it.err ? T : k + 1;
    it.rdata = (it.err || we) ? 32'd0 : sd;
    return it;
  endfunction

  task automatic push_item(input item_t it);
    slv_q.push_back(it);
    bus_q.push_back(it);
    rsp_q.push_back(it);
  endtask

  task automatic drive_cmd(input item_t it);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = it.we; cmd_addr = it.addr; cmd_wdata = it.wdata;
  endtask

  task automatic do_cmd(input bit we, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] sd, input int k);
    item_t it;
    bit ok;
    it = make_item(we, a, wd, sd, k);
    push_item(it);
    drive_cmd(it);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("cmd_accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && bus_q.size() == 0 && !rsp_valid && !wb_cyc_o) begin ok = 1; break; end
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Slave: ack after k wait cycles; a timed-out transfer gets a late ack while the master is in RESP.
  initial begin
    item_t cur;
    int    cnt;
    bit    busy;
    busy = 0; cnt = 0;
    wb_ack_i = 1'b0; wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
      if (!rst_n) begin
        busy = 0;
      end else if (busy && !wb_cyc_o) begin
        busy = 0;
        if (cur.k >= T) wb_ack_i = 1'b1;
      end else if (!busy && wb_cyc_o) begin
        if (slv_q.size() == 0) begin
          total++; bad++;
          $display("FAIL slave_unexpected_cycle: cyc=1 with no command issued");
        end else begin
          cur = slv_q.pop_front();
          busy = 1; cnt = 0;
        end
      end
      if (busy && wb_cyc_o) begin
        if (cnt == cur.k) begin wb_ack_i = 1'b1; wb_dat_i = cur.sdat; end
        cnt++;
      end
    end
  end

  // Monitor: bus-side stability and length, response contents and hold under backpressure.
  initial begin
    item_t e;
    bit    cyc_prev, rsp_seen;
    int    stb_cnt;
    logic [32:0] hold;
    cyc_prev = 0; rsp_seen = 0; stb_cnt = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc_prev = 0; rsp_seen = 0; stb_cnt = 0;
      end else begin
        if (wb_cyc_o !== wb_stb_o) chk("cyc_eq_stb", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
        if (wb_cyc_o || rsp_valid) chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        if (wb_cyc_o && bus_q.size() != 0) begin
          chk("wb_adr_o", {24'd0, wb_adr_o}, {24'd0, bus_q[0].addr});
          chk("wb_dat_o", wb_dat_o, bus_q[0].wdata);
          chk("wb_we_o", {31'd0, wb_we_o}, {31'd0, bus_q[0].we});
          stb_cnt++;
        end
        if (cyc_prev && !wb_cyc_o && bus_q.size() != 0) begin
          e = bus_q.pop_front();
          chk("stb_len", stb_cnt, e.len);
          stb_cnt = 0;
        end
        if (rsp_valid) begin
          if (!rsp_seen) begin
            if (rsp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h err=%b with nothing expected", rsp_rdata, rsp_err);
            end else begin
              e = rsp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
            hold = {rsp_err, rsp_rdata};
            rsp_seen = 1;
          end else begin
            chk("rsp_hold", {rsp_err, rsp_rdata}, hold);
          end
          if (rsp_ready) rsp_seen = 0;
        end
        cyc_prev = wb_cyc_o;
      end
    end
  end

  initial begin
    item_t b;
    bit    ok;
    bit    pat[20];
    int    pulses;
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; wb_int_i = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_bus", {wb_adr_o, 23'd0, wb_we_o} ^ wb_dat_o, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err} | rsp_rdata, 32'd0);
    chk("rst_irq", {31'd0, irq_pulse}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_first_edge", {31'd0, cmd_ready}, 32'd1);

    // directed write, read with 3 wait cycles (ack on timeout edge), and timeout with late ack
    do_cmd(1'b1, 8'h08, 32'hDEADBEEF, 32'hA5A5A5A5, 0);
    do_cmd(1'b0, 8'h10, 32'h0BADF00D, 32'h12345678, 3);
    do_cmd(1'b0, 8'h20, 32'h0, 32'hCAFEBABE, 20);
    wait_idle();

    for (int n = 0; n < 40; n++)
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, $urandom_range(0, 6));
    wait_idle();

    // backpressure: response held 5 cycles with a pending command
    @(negedge clk); rsp_mode = 1;
    do_cmd(1'b0, 8'h44, 32'h0, 32'h600DCAFE, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("bp_rsp_seen", {31'd0, ok}, 32'd1);
    b = make_item(1'b1, 8'h55, 32'h13572468, 32'h0, 2);
    push_item(b);
    drive_cmd(b);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_mode = 2;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1; break; end
    end
    chk("bp_release", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("bp_idle_ready", {29'd0, cmd_ready, rsp_valid, wb_cyc_o}, 32'b100);
    @(negedge clk);
    chk("bp_accept_next_edge", {31'd0, wb_cyc_o}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); rsp_mode = 0;
    wait_idle();

    // reset in the middle of a bus cycle
    do_cmd(1'b0, 8'h77, 32'h0, 32'h11111111, 100);
    @(negedge clk);
    chk("pre_reset_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst_n = 1'b0;
    bus_q.delete(); rsp_q.delete(); slv_q.delete();
    #1;
    chk("async_cyc_drop", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("async_adr_clear", {24'd0, wb_adr_o}, 32'd0);
    chk("async_ready_low", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_high", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, rsp_valid, wb_cyc_o}, 32'd0);
    end
    do_cmd(1'b0, 8'h99, 32'h0, 32'h87654321, 2);
    wait_idle();

    // interrupt edge detection: held high 10 cycles, low 1, high again
    for (int c = 0; c < 20; c++) pat[c] = (c < 10) || (c >= 11 && c < 14);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 wb_int_i = pat[c];
      @(negedge clk);
      chk("irq_pulse", {31'd0, irq_pulse},
          {31'd0, (c >= 1) && pat[c-1] && ((c < 2) || !pat[c-2])});
      if (irq_pulse) pulses++;
    end
    chk("irq_count", pulses, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum bus cycles to wait for wb_ack_i (legal range 1..65535).
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port wb_rst_n_i, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit, command request from the local host.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit, block can accept a command.
REQ-006 The block SHALL have port cmd_we, input, 1 bit, 1 = write, 0 = read.
REQ-007 The block SHALL have port cmd_addr, input, 8 bits, register address.
REQ-008 The block SHALL have port cmd_wdata, input, 32 bits, write data.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit, response available.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit, host accepts the response.
REQ-011 The block SHALL have port rsp_rdata, output, 32 bits, read data; 0 for writes and errors.
REQ-012 The block SHALL have port rsp_err, output, 1 bit, transaction timed out.
REQ-013 The block SHALL have port wb_adr_o, output, 8 bits; wb_dat_o, output, 32 bits; wb_we_o, output, 1 bit; wb_cyc_o, output, 1 bit; wb_stb_o, output, 1 bit; all are registered Wishbone master outputs.
REQ-014 The block SHALL have port wb_dat_i, input, 32 bits, and port wb_ack_i, input, 1 bit, both from the slave.
REQ-015 The block SHALL have port wb_int_i, input, 1 bit, slave interrupt, and port irq_pulse, output, 1 bit, a one-cycle pulse on each rising edge of wb_int_i.

Function
REQ-016 The state machine SHALL have the states IDLE, BUS and RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-018 On acceptance, the block SHALL register cmd_addr, cmd_wdata and cmd_we to wb_adr_o, wb_dat_o and wb_we_o, set wb_cyc_o and wb_stb_o to 1, clear the timeout counter, and go to BUS.
REQ-019 In BUS, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o and wb_stb_o SHALL hold stable until termination.
REQ-020 In BUS, an edge with wb_ack_i = 1 SHALL deassert wb_cyc_o and wb_stb_o, capture wb_dat_i into rsp_rdata when wb_we_o = 0 (0 when wb_we_o = 1), clear rsp_err, set rsp_valid, and go to RESP.
REQ-021 In BUS without wb_ack_i, the 16-bit timeout counter SHALL increment each cycle.
REQ-022 On the edge where the counter equals TIMEOUT_CYCLES-1 with wb_ack_i = 0, the block SHALL deassert wb_cyc_o and wb_stb_o, set rsp_err = 1, set rsp_rdata = 0, set rsp_valid, and go to RESP.
REQ-023 If wb_ack_i = 1 on the timeout edge, ack SHALL win: the transaction is a normal completion with rsp_err = 0.
REQ-024 wb_ack_i SHALL be ignored in IDLE and RESP.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold until an edge with rsp_ready = 1, which clears rsp_valid and returns to IDLE; a new command is accepted no earlier than the following edge.
REQ-026 Minimum latency: command accepted at edge N, wb_stb_o high after edge N, ack sampled at edge N+1, rsp_valid high after edge N+1.
REQ-027 Only one transaction SHALL be outstanding; wb_cyc_o and wb_stb_o are always equal.
REQ-028 irq_pulse SHALL be 1 for exactly one cycle after each edge where wb_int_i = 1 and its registered previous value = 0, independent of state.

Reset
REQ-029 While wb_rst_n_i = 0, the block SHALL immediately force state IDLE, cmd_ready = 0, wb_cyc_o = 0, wb_stb_o = 0, wb_we_o = 0, wb_adr_o = 0, wb_dat_o = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, irq_pulse = 0, counter = 0, and the previous-interrupt register = 0.
REQ-030 cmd_ready SHALL be 1 from the first edge after reset release.
REQ-031 A reset during BUS or RESP SHALL abort the transaction with no response generated.

Verification
REQ-032 Write: cmd_we = 1, addr = 0x08, wdata = 0xDEADBEEF, and the slave acks in the first bus cycle -> wb_adr_o = 0x08, wb_dat_o = 0xDEADBEEF, wb_we_o = 1 for 1 cycle, then rsp_valid with rsp_err = 0 and rsp_rdata = 0.
REQ-033 Read: addr = 0x10, and the slave returns 0x12345678 with ack after 3 wait cycles -> stb held for 4 cycles, then rsp_rdata = 0x12345678 and rsp_err = 0.
REQ-034 Timeout: TIMEOUT_CYCLES = 4 with no ack -> stb high for exactly 4 cycles, then rsp_err = 1 and rsp_rdata = 0; a late ack in RESP is ignored.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles -> response stays stable, cmd_ready = 0, a pending cmd_valid is not accepted, and it is accepted the edge after rsp_ready = 1 returns the block to IDLE.
REQ-036 Reset asserted mid-BUS -> cyc/stb drop asynchronously, no rsp_valid appears, and cmd_ready = 1 on the first edge after release.
REQ-037 wb_int_i held high for 10 cycles, then toggled 0->1 -> exactly two single-cycle irq_pulse events.
